// File: rtl/img_proc_pkg.sv
// ---------------------------------------------------------------------------
// img_proc_pkg
// Shared definitions for the video image processor binary stages.
//   PIX_WHITE / PIX_BLACK : 24-bit binary pixel encodings
//   IMG_WIDTH_DEF         : default active pixels per line
//   win3x3_t              : 3x3 binary window, [column][row-in-column]
//   win_reduce()          : 9-input AND (erosion) or OR (dilation)
// ---------------------------------------------------------------------------
package img_proc_pkg;

  localparam logic [23:0] PIX_WHITE     = 24'hFFFFFF;
  localparam logic [23:0] PIX_BLACK     = 24'h000000;
  localparam int          IMG_WIDTH_DEF = 640;

  // w[j] is a window column, j = 2 newest (current column), j = 0 oldest.
  // w[j][k]: k = 0 current row, k = 1 one line up, k = 2 two lines up.
  typedef logic [2:0][2:0] win3x3_t;

  function automatic logic win_reduce(input win3x3_t w, input logic dilate);
    return dilate ? (|w) : (&w);
  endfunction

endpackage

// File: rtl/line_buffer_1b.sv
// ---------------------------------------------------------------------------
// line_buffer_1b
// Two 1-bit line memories packed as 2-bit words at one address per column.
// Bit 0 holds the previous line, bit 1 the line before it. A write pushes
// the new bit into bit 0 and the old bit 0 into bit 1 (read-before-write at
// the same address), so one access per pixel keeps both lines in step.
// Ports:
//   i_clk   pixel clock
//   i_we    write enable (one accepted pixel)
//   i_addr  column address (only the low $clog2(DEPTH) bits are decoded)
//   i_din   new pixel bit
//   o_tap1  pixel one line up at i_addr   (combinational read)
//   o_tap2  pixel two lines up at i_addr  (combinational read)
// ---------------------------------------------------------------------------
module line_buffer_1b
  import img_proc_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic          i_din,
  output logic          o_tap1,
  output logic          o_tap2
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    r_mem [DEPTH];
  logic [IW-1:0] w_idx;
  logic [1:0]    w_word;
  logic          w_unused_addr;

  // The column counter may be wider than the array needs; upper bits are 0.
  assign w_idx         = i_addr[IW-1:0];
  assign w_unused_addr = ^i_addr;

  assign w_word = r_mem[w_idx];
  assign o_tap1 = w_word[0];
  assign o_tap2 = w_word[1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[w_idx] <= {w_word[0], i_din};
  end

endmodule

// File: rtl/binary_morph_3x3.sv
// ---------------------------------------------------------------------------
// binary_morph_3x3
// Streaming 3x3 binary erosion (default) or dilation (MORPH_DILATE_EN
// defined) on a 24-bit all-zeros/all-ones pixel stream. One output pixel per
// accepted input; sideband (vsync/clken/valid) delayed by exactly 2 cycles.
// Output for accepted pixel (r,c) is the reduce of the window centred on
// (r-1,c-1); neighbours above row 0 or left of column 0 read as 0.
// Ports:
//   i_clk               pixel clock
//   i_rst_n             synchronous active-low reset
//   i_pre_image_vsync   frame sync, rising edge restarts at (0,0)
//   i_pre_image_clken   pixel clock enable
//   i_pre_data_valid    pixel valid (accept = clken && valid)
//   i_pre_image_data    binary pixel, bit 0 used
//   o_pos_image_vsync   vsync delayed 2 cycles
//   o_pos_image_clken   clken delayed 2 cycles
//   o_pos_data_valid    valid delayed 2 cycles
//   o_pos_image_data    filtered pixel, PIX_WHITE or PIX_BLACK
// Build option: MORPH_DILATE_EN selects OR reduce (dilation).
// ---------------------------------------------------------------------------
module binary_morph_3x3
  import img_proc_pkg::*;
#(
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int COL_W     = 10,
  parameter int ROW_W     = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pre_image_vsync,
  input  logic        i_pre_image_clken,
  input  logic        i_pre_data_valid,
  input  logic [23:0] i_pre_image_data,
  output logic        o_pos_image_vsync,
  output logic        o_pos_image_clken,
  output logic        o_pos_data_valid,
  output logic [23:0] o_pos_image_data
);

`ifdef MORPH_DILATE_EN
  localparam logic DILATE = 1'b1;
`else
  localparam logic DILATE = 1'b0;
`endif

  // ---- state ----
  logic             r_vs_d;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  win3x3_t          r_win;
  logic [1:0]       r_vs_pipe;
  logic [1:0]       r_ce_pipe;
  logic [1:0]       r_dv_pipe;
  logic             r_pix;

  // ---- stage 1 combinational ----
  logic             w_acc;
  logic             w_vs_rise;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  win3x3_t          w_win;
  logic             w_tap1;
  logic             w_tap2;
  logic             w_m1;
  logic             w_m2;
  logic             w_col_last;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  win3x3_t          w_win_nxt;
  logic             w_unused;

  assign w_unused  = ^i_pre_image_data[23:1];
  assign w_acc     = i_pre_image_clken & i_pre_data_valid;
  assign w_vs_rise = i_pre_image_vsync & ~r_vs_d;

  // A vsync edge takes effect in its own cycle, so a pixel accepted
  // alongside it is already (0,0) with an empty window.
  assign w_col = w_vs_rise ? '0 : r_col;
  assign w_row = w_vs_rise ? '0 : r_row;
  assign w_win = w_vs_rise ? '0 : r_win;

  line_buffer_1b #(
    .DEPTH (IMG_WIDTH),
    .AW    (COL_W)
  ) u_lbuf (
    .i_clk  (i_clk),
    .i_we   (w_acc & i_rst_n),
    .i_addr (w_col),
    .i_din  (i_pre_image_data[0]),
    .o_tap1 (w_tap1),
    .o_tap2 (w_tap2)
  );

  // Line buffers are never cleared; row masking hides lines from an earlier
  // frame (or from before reset).
  assign w_m1 = (w_row != '0) & w_tap1;
  assign w_m2 = (w_row > ROW_W'(1)) & w_tap2;

  always_comb begin
    w_win_nxt    = '0;
    w_win_nxt[2] = {w_m2, w_m1, i_pre_image_data[0]};
    // Shifted-in columns belong to the previous line at the start of a line.
    w_win_nxt[1] = (w_col == '0)        ? 3'b000 : w_win[2];
    w_win_nxt[0] = (w_col < COL_W'(2))  ? 3'b000 : w_win[1];
  end

  assign w_col_last = (w_col == COL_W'(IMG_WIDTH - 1));
  assign w_col_nxt  = w_col_last ? '0 : (w_col + COL_W'(1));

  always_comb begin
    w_row_nxt = w_row;
    if (w_col_last && !(&w_row)) w_row_nxt = w_row + ROW_W'(1);
  end

  // ---- registers ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vs_d    <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_win     <= '0;
      r_vs_pipe <= '0;
      r_ce_pipe <= '0;
      r_dv_pipe <= '0;
      r_pix     <= 1'b0;
    end else begin
      r_vs_d    <= i_pre_image_vsync;
      r_vs_pipe <= {r_vs_pipe[0], i_pre_image_vsync};
      r_ce_pipe <= {r_ce_pipe[0], i_pre_image_clken};
      r_dv_pipe <= {r_dv_pipe[0], i_pre_data_valid};

      if (w_acc) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        r_win <= w_win_nxt;
      end else if (w_vs_rise) begin
        r_col <= '0;
        r_row <= '0;
        r_win <= '0;
      end

      // Stage 2: r_win holds the window of the pixel accepted last cycle.
      if (r_ce_pipe[0] && r_dv_pipe[0]) r_pix <= win_reduce(r_win, DILATE);
    end
  end

  assign o_pos_image_vsync = r_vs_pipe[1];
  assign o_pos_image_clken = r_ce_pipe[1];
  assign o_pos_data_valid  = r_dv_pipe[1];
  assign o_pos_image_data  = r_pix ? PIX_WHITE : PIX_BLACK;

endmodule

// File: tb/tb_binary_morph_3x3.sv
module tb_binary_morph_3x3;
  import img_proc_pkg::*;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
`ifdef MORPH_DILATE_EN
  localparam bit DIL = 1'b1;
`else
  localparam bit DIL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, vs = 1'b0, ce = 1'b0, dv = 1'b0;
  logic [23:0] din = '0;
  logic        pvs, pce, pdv;
  logic [23:0] pdat;

  binary_morph_3x3 #(.IMG_WIDTH(W), .COL_W(10), .ROW_W(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pre_image_vsync(vs), .i_pre_image_clken(ce),
    .i_pre_data_valid(dv), .i_pre_image_data(din),
    .o_pos_image_vsync(pvs), .o_pos_image_clken(pce),
    .o_pos_data_valid(pdv), .o_pos_image_data(pdat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame kept as a flat list of accepted bits since the last frame start;
  // pixel n sits at (n / W, n % W). Neighbours off the top/left read 0.
  bit frame_q[$];
  bit m_prev_vs = 1'b0;

  typedef struct packed {
    logic rst, vs, ce, dv, acc, exp;
  } ent_t;

  ent_t        p1 = '0, p2 = '0;
  logic [23:0] exp_hold = '0;
  int          white_cnt = 0, out_cnt = 0;
  bit          cap_en = 1'b0;
  bit          cap_q[$];

  function automatic bit nbhd(input int n);
    int r, c, rr, cc;
    bit acc, b;
    r = n / W;
    c = n % W;
    acc = DIL ? 1'b0 : 1'b1;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        rr = r - dr;
        cc = c - dc;
        b = (rr >= 0 && cc >= 0) ? frame_q[rr * W + cc] : 1'b0;
        acc = DIL ? (acc | b) : (acc & b);
      end
    return acc;
  endfunction

  function automatic ent_t model_step(input logic r, v, c, d, px);
    ent_t e;
    e = '0;
    if (!r) begin
      frame_q.delete();
      m_prev_vs = 1'b0;
      e.rst = 1'b1;
      return e;
    end
    if (v && !m_prev_vs) frame_q.delete();
    m_prev_vs = v;
    e.vs = v; e.ce = c; e.dv = d; e.acc = c & d;
    if (e.acc) begin
      frame_q.push_back(px);
      e.exp = nbhd(frame_q.size() - 1);
    end
    return e;
  endfunction

  // Inputs seen at negedge n are sampled at the following posedge; the
  // outputs at negedge n reflect the inputs seen two negedges earlier.
  always @(negedge clk) begin
    if (p1.rst) begin
      p1 = '0;
      p2 = '0;
      exp_hold = '0;
    end
    if (p2.acc) exp_hold = {24{p2.exp}};
    chk("pos_vsync", pvs, p2.vs);
    chk("pos_clken", pce, p2.ce);
    chk("pos_valid", pdv, p2.dv);
    chk("pos_data",  pdat, exp_hold);
    if (pce && pdv) begin
      out_cnt++;
      if (pdat == PIX_WHITE) white_cnt++;
      if (cap_en) cap_q.push_back(pdat[0]);
    end
    p2 = p1;
    p1 = model_step(rst_n, vs, ce, dv, din[0]);
  end

  // ---------------- stimulus ----------------
  bit frm [N];

  task automatic drv(input logic r, v, c, d, px);
    logic [22:0] junk;
    @(posedge clk);
    #1;
    junk  = 23'($urandom());
    rst_n = r; vs = v; ce = c; dv = d;
    din   = {junk, px};
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1, 0, 0, 0, 0);
  endtask

  task automatic gen(input int kind);
    for (int n = 0; n < N; n++) begin
      case (kind)
        0:       frm[n] = 1'b1;
        1:       frm[n] = 1'b0;
        2:       frm[n] = (n / W == 3) && (n % W == 3);
        default: frm[n] = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic drive_frame(input bit gap, input bit vs_first);
    if (!vs_first) drv(1, 1, 0, 0, 0);
    for (int n = 0; n < N; n++) begin
      drv(1, vs_first && (n == 0), 1, 1, frm[n]);
      if (gap) drv(1, 0, 1, 0, frm[n]);
    end
  endtask

  typedef struct {
    int kind;
    bit gap;
    int wh_erode;
    int wh_dilate;
  } vec_t;

  vec_t vt [5];

  initial begin
    int cnt, mis;

    vt[0] = '{0, 1'b0, 24, 48};   // all white, continuous
    vt[1] = '{2, 1'b0,  0,  9};   // single white at (3,3)
    vt[2] = '{0, 1'b1, 24, 48};   // all white, valid toggling
    vt[3] = '{1, 1'b0,  0,  0};   // all black
    vt[4] = '{2, 1'b1,  0,  9};   // single white, gapped

    repeat (3) drv(0, 0, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 5; i++) begin
      gen(vt[i].kind);
      white_cnt = 0;
      out_cnt   = 0;
      drive_frame(vt[i].gap, 1'b0);
      idle(3);
      chk($sformatf("vec%0d_whites", i), white_cnt, DIL ? vt[i].wh_dilate : vt[i].wh_erode);
      chk($sformatf("vec%0d_outs", i), out_cnt, N);
    end

    // vsync rising edge mid-line (row 2, col 4) of an all-white stream
    gen(0);
    cap_q.delete();
    cap_en = 1'b1;
    drv(1, 1, 0, 0, 0);
    for (int n = 0; n < 20; n++) drv(1, 0, 1, 1, 1);
    for (int n = 0; n < N; n++) drv(1, (n == 0), 1, 1, 1);
    idle(3);
    cap_en = 1'b0;
    chk("vsmid_size", cap_q.size(), 20 + N);
    chk("vsmid_prev_r2c3", cap_q[19], 1);
    cnt = 0;
    for (int k = 20; k < 20 + 2 * W + 2; k++) cnt += cap_q[k];
    chk("vsmid_head_whites", cnt, DIL ? (2 * W + 2) : 0);
    cnt = 0;
    for (int k = 20; k < 20 + N; k++) cnt += cap_q[k];
    chk("vsmid_frame_whites", cnt, DIL ? N : 24);

    // one-cycle reset mid-frame
    drv(1, 1, 0, 0, 0);
    for (int n = 0; n < 27; n++) drv(1, 0, 1, 1, 1);
    drv(0, 0, 1, 1, 1);
    drv(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_pos_vsync", pvs, 0);
    chk("rst_pos_clken", pce, 0);
    chk("rst_pos_valid", pdv, 0);
    chk("rst_pos_data",  pdat, PIX_BLACK);
    idle(2);
    white_cnt = 0;
    out_cnt   = 0;
    drive_frame(1'b0, 1'b0);
    idle(3);
    chk("rst_frame_whites", white_cnt, DIL ? N : 24);
    chk("rst_frame_outs", out_cnt, N);

    // back-to-back random frames, vsync on the first pixel of frame 2
    gen(3);
    cap_q.delete();
    cap_en = 1'b1;
    drive_frame(1'b0, 1'b0);
    drive_frame(1'b0, 1'b1);
    idle(3);
    cap_en = 1'b0;
    chk("b2b_size", cap_q.size(), 2 * N);
    mis = 0;
    if (cap_q.size() == 2 * N)
      for (int k = 0; k < N; k++) mis += (cap_q[k] != cap_q[k + N]) ? 1 : 0;
    chk("b2b_identical", mis, 0);

    // random free-running stream against the model
    for (int k = 0; k < 3000; k++) begin
      drv(($urandom_range(0, 499) != 0),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 4) != 0));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
